// File: rtl/oscillator.sv
// Programmable clock generator: emits a registered, glitch-free clk_out of P reference cycles
// with edge ticks. Optional macro OSCILLATOR_CYCLE_COUNT_EN adds a 32-bit rise counter output.
module oscillator #(
    parameter int PERIOD = 10,
    parameter int PW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [PW-1:0] period_in,
    input  logic          period_load,
    output logic          clk_out,
    output logic          rise_tick,
    output logic          fall_tick,
    output logic          running
`ifdef OSCILLATOR_CYCLE_COUNT_EN
    ,
    output logic [31:0]   cycle_count
`endif
);

    localparam logic [PW-1:0] P_RST = PW'(PERIOD);
    localparam logic [PW-1:0] P_MIN = PW'(2);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        r_state;
    logic [PW-1:0] r_ph;
    logic [PW-1:0] r_active;
    logic [PW-1:0] r_pending;
    logic          r_clk_out;
    logic          r_rise;
    logic          r_fall;

    state_t        w_state_nxt;
    logic [PW-1:0] w_ph_nxt;
    logic [PW-1:0] w_active_nxt;
    logic [PW-1:0] w_pending_nxt;
    logic [PW-1:0] w_load_val;
    logic          w_wrap;
    logic          w_clk_nxt;
    logic          w_rise_nxt;
    logic          w_fall_nxt;

    assign w_load_val    = (period_in < P_MIN) ? P_MIN : period_in;
    assign w_pending_nxt = period_load ? w_load_val : r_pending;
    assign w_wrap        = (r_state == S_RUN) && (r_ph == (r_active - P_ONE));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ph      <= P_RST - P_ONE;
            r_active  <= P_RST;
            r_pending <= P_RST;
            r_clk_out <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph      <= w_ph_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_clk_out <= w_clk_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
        end
    end

    // Next-state logic. At a wrap the old pending value is used, so a load in the
    // wrap cycle only lands at the following wrap.
    always_comb begin
        w_state_nxt  = r_state;
        w_ph_nxt     = r_ph;
        w_active_nxt = r_active;
        case (r_state)
            S_IDLE: begin
                w_active_nxt = w_pending_nxt;
                if (en) begin
                    w_state_nxt = S_RUN;
                    w_ph_nxt    = '0;
                end
            end
            S_RUN: begin
                if (w_wrap) begin
                    w_active_nxt = r_pending;
                    if (en) begin
                        w_ph_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_ph_nxt = r_ph + P_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_clk_nxt  = (w_state_nxt == S_RUN) && (w_ph_nxt < (w_active_nxt >> 1));
        w_rise_nxt = w_clk_nxt & ~r_clk_out;
        w_fall_nxt = ~w_clk_nxt & r_clk_out;
    end

    // Outputs
    always_comb begin
        clk_out   = r_clk_out;
        rise_tick = r_rise;
        fall_tick = r_fall;
        running   = (r_state == S_RUN);
    end

`ifdef OSCILLATOR_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= '0;
        end else if (w_rise_nxt) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_oscillator.sv
// Self-checking bench for oscillator: expected {running, clk_out, rise_tick, fall_tick}
// per cycle is queued from the period/phase definition and compared after each edge.
module tb_oscillator;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] period_in;
  logic       period_load;
  logic       clk_out;
  logic       rise_tick;
  logic       fall_tick;
  logic       running;
`ifdef OSCILLATOR_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  logic [3:0] exp_q[$];
  logic [3:0] got;
  logic [3:0] exp;
  int         n_checks;
  int         n_fail;

  oscillator #(.PERIOD(10), .PW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .period_in   (period_in),
    .period_load (period_load),
    .clk_out     (clk_out),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick),
    .running     (running)
`ifdef OSCILLATOR_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected sample at phase k of a running period p: high for k < floor(p/2).
  function automatic logic [3:0] exp_run(input int p, input int k);
    int h;
    h = p / 2;
    return {1'b1, (k < h), (k == 0), (k == h)};
  endfunction

  task automatic push_period(input int p, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) exp_q.push_back(exp_run(p, k));
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(4'b0000);
  endtask

  task automatic test_reset;
    #3;
    exp_q.push_back(4'b0000);
    got = {running, clk_out, rise_tick, fall_tick};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_initial: got %b expected %b", got, exp);
    end
    push_idle(2);
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_held: got %b expected %b", got, exp);
      end
    end
    reset = 1'b1;
    push_idle(2);
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL idle_en0: got %b expected %b", got, exp);
      end
    end
  endtask

  task automatic test_default_run;
    int i;
    en = 1'b1;
    for (int n = 0; n < 3; n++) push_period(10, 0, 9);
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL default_run cyc %0d: got %b expected %b", i, got, exp);
      end
      i++;
    end
`ifdef OSCILLATOR_CYCLE_COUNT_EN
    n_checks++;
    if (cycle_count !== 32'd3) begin
      n_fail++;
      $display("FAIL cycle_count: got %0d expected 3", cycle_count);
    end
`endif
  endtask

  task automatic test_stop;
    int i;
    push_period(10, 0, 9);
    push_idle(5);
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stop cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 2) en = 1'b0;
      i++;
    end
  endtask

  task automatic test_period_load;
    int i;
    en = 1'b1;
    push_period(10, 0, 9);
    for (int n = 0; n < 3; n++) push_period(4, 0, 3);
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL period_load cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 2) begin
        period_in   = 8'd4;
        period_load = 1'b1;
      end
      if (i == 3) period_load = 1'b0;
      i++;
    end
  endtask

  task automatic test_wrap_load;
    int i;
    push_period(4, 0, 3);
    push_period(4, 0, 3);
    push_period(6, 0, 5);
    push_period(6, 0, 5);
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL wrap_load cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 3) begin
        period_in   = 8'd6;
        period_load = 1'b1;
      end
      if (i == 4) period_load = 1'b0;
      i++;
    end
  endtask

  task automatic test_min_period;
    int i;
    push_period(6, 0, 5);
    for (int n = 0; n < 3; n++) push_period(2, 0, 1);
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL min_period cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 1) begin
        period_in   = 8'd1;
        period_load = 1'b1;
      end
      if (i == 2) period_load = 1'b0;
      i++;
    end
    push_period(2, 0, 1);
    push_period(7, 0, 6);
    push_period(7, 0, 6);
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL period7 cyc %0d: got %b expected %b", i, got, exp);
      end
      if (i == 0) begin
        period_in   = 8'd7;
        period_load = 1'b1;
      end
      if (i == 1) period_load = 1'b0;
      i++;
    end
  endtask

  task automatic test_async_reset;
    int i;
    push_period(7, 0, 1);
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL pre_reset: got %b expected %b", got, exp);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(4'b0000);
    got = {running, clk_out, rise_tick, fall_tick};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", got, exp);
    end
`ifdef OSCILLATOR_CYCLE_COUNT_EN
    n_checks++;
    if (cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL cycle_count_reset: got %0d expected 0", cycle_count);
    end
`endif
    #1;
    reset = 1'b1;
    en    = 1'b1;
    push_period(10, 0, 9);
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      got = {running, clk_out, rise_tick, fall_tick};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d: got %b expected %b", i, got, exp);
      end
      i++;
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    en          = 1'b0;
    period_in   = 8'd0;
    period_load = 1'b0;
    test_reset();
    test_default_run();
    test_stop();
    test_period_load();
    test_wrap_load();
    test_min_period();
    test_async_reset();
    en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
